gpio_pwm_out_core: RTL and testbench

//  Parametrised general-purpose output core on the MMIO slot bus; successor to the plain latched-output core.

---
 rtl/gpio_pwm_out_core.sv | 146 ++++++++++++++
 tb/tb_gpio_pwm_out_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pwm_out_core.sv
// Slot-bus output core: per-channel static/PWM select, atomic set/clear, readback,
// and a shared prescaled PWM timebase whose duty values are shadowed per period.
module gpio_pwm_out_core #(
  parameter int DATA_WIDTH     = 16,
  parameter int PWM_RES        = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read,
  input  logic                  write,
  input  logic [4:0]            reg_addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [4:0] ADDR_OUT  = 5'h00;
  localparam logic [4:0] ADDR_SET  = 5'h01;
  localparam logic [4:0] ADDR_CLR  = 5'h02;
  localparam logic [4:0] ADDR_MODE = 5'h03;
  localparam logic [4:0] ADDR_PSC  = 5'h04;
  localparam logic [4:0] ADDR_PINS = 5'h05;
  localparam int         DUTY_BASE = 16;

  logic [DATA_WIDTH-1:0]     out_q, out_d;
  logic [DATA_WIDTH-1:0]     mode_q, mode_d;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic [PRESCALE_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic [PWM_RES-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [PWM_RES:0]          duty_q   [DATA_WIDTH];
  logic [PWM_RES:0]          duty_d   [DATA_WIDTH];
  logic [PWM_RES:0]          shadow_q [DATA_WIDTH];
  logic [PWM_RES:0]          shadow_d [DATA_WIDTH];
  logic [DATA_WIDTH-1:0]     data_out_q, data_out_d;

  logic                      wr_en_s;
  logic                      tick_s;
  logic                      wrap_s;
  logic [DATA_WIDTH-1:0]     level_s;
  logic [31:0]               rd_data_s;
  logic                      bus_unused_s;

  assign wr_en_s      = cs && write;
  assign tick_s       = (psc_cnt_q == psc_q);
  assign wrap_s       = tick_s && (pwm_cnt_q == {PWM_RES{1'b1}});
  // read strobe is only a bus qualifier; upper write-data bits have no storage
  assign bus_unused_s = ^{read, wr_data};

  // Next-state: timebase advance, period-start shadow reload, then register writes
  always_comb begin
    out_d     = out_q;
    mode_d    = mode_q;
    psc_d     = psc_q;
    psc_cnt_d = psc_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    shadow_d  = shadow_q;

    if (tick_s) begin
      psc_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + PWM_RES'(1);
      shadow_d  = wrap_s ? duty_q : shadow_q;
    end else begin
      psc_cnt_d = psc_cnt_q + PRESCALE_WIDTH'(1);
    end

    if (wr_en_s) begin
      case (reg_addr)
        ADDR_OUT:  out_d  = wr_data[DATA_WIDTH-1:0];
        ADDR_SET:  out_d  = out_q | wr_data[DATA_WIDTH-1:0];
        ADDR_CLR:  out_d  = out_q & ~wr_data[DATA_WIDTH-1:0];
        ADDR_MODE: mode_d = wr_data[DATA_WIDTH-1:0];
        ADDR_PSC: begin
          // new divisor restarts the period with fresh duties
          psc_d     = wr_data[PRESCALE_WIDTH-1:0];
          psc_cnt_d = '0;
          pwm_cnt_d = '0;
          shadow_d  = duty_q;
        end
        default: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            duty_d[i] = (reg_addr == 5'(DUTY_BASE + i)) ? wr_data[PWM_RES:0] : duty_q[i];
          end
        end
      endcase
    end else begin
      out_d = out_q;
    end
  end

  // PWM compare and static/PWM output select
  always_comb begin
    level_s = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      level_s[i] = ({1'b0, pwm_cnt_q} < shadow_q[i]);
    end
    data_out_d = (mode_q & level_s) | (~mode_q & out_q);
  end

  // Register readback mux, side-effect free
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (reg_addr)
      ADDR_OUT:  rd_data_s = 32'(out_q);
      ADDR_MODE: rd_data_s = 32'(mode_q);
      ADDR_PSC:  rd_data_s = 32'(psc_q);
      ADDR_PINS: rd_data_s = 32'(data_out_q);
      default: begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          rd_data_s = (reg_addr == 5'(DUTY_BASE + i)) ? 32'(duty_q[i]) : rd_data_s;
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      mode_q     <= '0;
      psc_q      <= '0;
      psc_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      data_out_q <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        duty_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      out_q      <= out_d;
      mode_q     <= mode_d;
      psc_q      <= psc_d;
      psc_cnt_q  <= psc_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      data_out_q <= data_out_d;
      duty_q     <= duty_d;
      shadow_q   <= shadow_d;
    end
  end

  assign rd_data  = rd_data_s;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_gpio_pwm_out_core.sv
// Self-checking bench for gpio_pwm_out_core: directed scenarios plus random bus traffic
// compared every cycle against an arithmetic model of the register map and PWM timebase.
`timescale 1ns/1ps
module tb_gpio_pwm_out_core;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, cs, read, write;
  logic [4:0]    reg_addr;
  logic [31:0]   wr_data, rd_data;
  logic [DW-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents, clocks since timebase restart, per-period duties
  logic [15:0] m_out, m_mode, m_psc, m_dout;
  int          m_duty   [DW];
  int          m_shadow [DW];
  longint      m_cnt;

  gpio_pwm_out_core #(.DATA_WIDTH(16), .PWM_RES(8), .PRESCALE_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = '0; m_mode = '0; m_psc = '0; m_dout = '0; m_cnt = 0;
    for (int i = 0; i < DW; i++) begin
      m_duty[i] = 0; m_shadow[i] = 0;
    end
  endtask

  // Output the DUT should register on the next edge, from the current model state
  function automatic logic [15:0] m_next_dout();
    longint      pos;
    logic [15:0] v;
    pos = (m_cnt / (longint'(m_psc) + 1)) % 256;
    for (int i = 0; i < DW; i++) v[i] = m_mode[i] ? (pos < m_shadow[i]) : m_out[i];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'h00:   return {16'h0, m_out};
      5'h03:   return {16'h0, m_mode};
      5'h04:   return {16'h0, m_psc};
      5'h05:   return {16'h0, m_dout};
      default: return (a >= 5'h10) ? 32'(m_duty[int'(a[3:0])]) : 32'h0;
    endcase
  endfunction

  // One bus cycle: drive, clock, advance model, check data_out (and rd_data on reads)
  task automatic bus(input logic c, input logic w, input logic r,
                     input logic [4:0] a, input logic [31:0] d);
    logic [15:0] nxt;
    cs = c; write = w; read = r; reg_addr = a; wr_data = d;
    @(posedge clk);
    nxt = m_next_dout();
    m_cnt++;
    if (m_cnt % ((longint'(m_psc) + 1) * 256) == 0)
      for (int i = 0; i < DW; i++) m_shadow[i] = m_duty[i];
    if (c && w) begin
      case (a)
        5'h00: m_out = d[15:0];
        5'h01: m_out = m_out | d[15:0];
        5'h02: m_out = m_out & ~d[15:0];
        5'h03: m_mode = d[15:0];
        5'h04: begin
          m_psc = d[15:0];
          m_cnt = 0;
          for (int i = 0; i < DW; i++) m_shadow[i] = m_duty[i];
        end
        default: if (a >= 5'h10) m_duty[int'(a[3:0])] = int'(d[8:0]);
      endcase
    end
    m_dout = nxt;
    #1;
    check_eq("dout", {16'h0, data_out}, {16'h0, m_dout});
    if (r) check_eq("rd", rd_data, m_read(a));
    cs = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    bus(1'b1, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      bus(1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
      hi += int'(data_out[0]);
    end
  endtask

  // Async reset pulse between edges; outputs must clear before any clock
  task automatic pulse_reset();
    #3 reset = 1'b1;
    #1 check_eq("rst_async_dout", {16'h0, data_out}, 32'h0);
    m_reset();
    #2 reset = 1'b0;
  endtask

  initial begin
    int hi;
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; reg_addr = 5'h00; wr_data = 32'h0;
    m_reset();
    #12 reset = 1'b0;
    check_eq("rst_dout", {16'h0, data_out}, 32'h0);
    for (int a = 0; a < 32; a++) rd(5'(a));

    // atomic set/clear with one-cycle output latency
    wr(5'h00, 32'h0000_A5A5);
    wr(5'h01, 32'h0000_000F);
    check_eq("set_lag", {16'h0, data_out}, 32'h0000_A5A5);
    idle(1);
    check_eq("set_dout", {16'h0, data_out}, 32'h0000_A5AF);
    wr(5'h02, 32'h0000_00A0);
    idle(1);
    check_eq("clr_dout", {16'h0, data_out}, 32'h0000_A50F);
    rd(5'h00);
    check_eq("out_rd", rd_data, 32'h0000_A50F);

    // PWM duty 64 of 256, then the two limits
    wr(5'h10, 32'd64); wr(5'h03, 32'h1); wr(5'h04, 32'h0);
    count_high(256, hi); check_eq("pwm64_high", 32'(hi), 32'd64);
    wr(5'h10, 32'd0);   wr(5'h04, 32'h0);
    count_high(256, hi); check_eq("duty0_high", 32'(hi), 32'd0);
    wr(5'h10, 32'd256); wr(5'h04, 32'h0);
    count_high(256, hi); check_eq("duty256_high", 32'(hi), 32'd256);

    // mid-period duty write waits for the next period
    wr(5'h10, 32'd64); wr(5'h04, 32'h0);
    idle(100);
    wr(5'h10, 32'd200);
    count_high(100, hi); check_eq("shadow_hold", 32'(hi), 32'd0);
    idle(56);
    count_high(256, hi); check_eq("shadow_new", 32'(hi), 32'd200);

    // prescaled period and mid-period restart
    wr(5'h10, 32'd128); wr(5'h04, 32'd3);
    count_high(1024, hi); check_eq("psc3_high", 32'(hi), 32'd512);
    idle(300);
    wr(5'h04, 32'd3);
    count_high(512, hi); check_eq("psc_restart", 32'(hi), 32'd512);

    // bus corner cases
    bus(1'b0, 1'b1, 1'b0, 5'h00, 32'h0000_FFFF);
    rd(5'h00);
    check_eq("cs0_ignored", rd_data, 32'h0000_A50F);
    wr(5'h05, 32'hFFFF_FFFF);
    for (int a = 1; a < 16; a++) rd(5'(a));
    wr(5'h13, 32'hFFFF_FFFF);
    rd(5'h13);
    check_eq("duty_mask", rd_data, 32'h0000_01FF);

    // reset in the middle of a PWM period
    wr(5'h00, 32'h0000_FFFF);
    idle(50);
    pulse_reset();
    for (int a = 0; a < 32; a++) rd(5'(a));
    idle(4);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int op;
      op = $urandom_range(0, 11);
      case (op)
        0: wr(5'h00, $urandom);
        1: wr(5'h01, $urandom);
        2: wr(5'h02, $urandom);
        3: wr(5'h03, $urandom);
        4: if ($urandom_range(0, 7) == 0) wr(5'h04, ($urandom << 16) | 32'($urandom_range(0, 3)));
           else idle(1);
        5: wr(5'(16 + $urandom_range(0, 15)), ($urandom << 9) | 32'($urandom_range(0, 300)));
        6: rd(5'($urandom_range(0, 31)));
        7: bus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        default: idle(1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
